ready_gen_mc: RTL



---
 rtl/ready_gen_mc.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ready_gen_mc.sv
// ready_gen_mc: multi-channel programmable ready generator.
// Each channel times a request with its own delay. It raises ready together
// with the request ID captured when the request rose. In level mode ready
// holds while the request stays high; in pulse mode ready lasts one enabled
// cycle per request.
module ready_gen_mc #(
  parameter int CHANNELS    = 4,
  parameter int IDW         = 4,
  parameter int MAX_DLY     = 15,
  parameter int DEFAULT_DLY = 3,
  localparam int CW         = $clog2(MAX_DLY + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    ce_i,
  input  logic [CHANNELS-1:0]     req_i,
  input  logic [CHANNELS*IDW-1:0] id_i,
  input  logic                    cfg_we_i,
  input  logic [3:0]              cfg_ch_i,
  input  logic [CW-1:0]           cfg_dly_i,
  input  logic                    cfg_pulse_i,
  output logic [CHANNELS-1:0]     rdy_o,
  output logic [CHANNELS*IDW-1:0] id_o,
  output logic                    busy_o
);

  localparam logic [CW-1:0] MAX_DLY_C     = CW'(MAX_DLY);
  localparam logic [CW-1:0] DEFAULT_DLY_C = CW'(DEFAULT_DLY);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_READY,
    ST_DONE
  } state_t;

  state_t              state_q [CHANNELS];
  state_t              state_d [CHANNELS];
  logic [CW-1:0]       cnt_q   [CHANNELS];
  logic [CW-1:0]       cnt_d   [CHANNELS];
  logic [IDW-1:0]      idl_q   [CHANNELS];
  logic [IDW-1:0]      idl_d   [CHANNELS];
  logic [CW-1:0]       dly_q   [CHANNELS];
  logic                pulse_q [CHANNELS];

  logic [CHANNELS-1:0]     rdy_d;
  logic [CHANNELS*IDW-1:0] id_d;
  logic                    busy_d;
  logic [CW-1:0]           cfg_dly_clamped;

  // Out-of-range delay writes saturate at the largest supported delay
  always_comb begin
    cfg_dly_clamped = cfg_dly_i;
    if (cfg_dly_i > MAX_DLY_C) begin
      cfg_dly_clamped = MAX_DLY_C;
    end
  end

  // Config registers: written whenever strobed, independent of the clock enable.
  // Writes to channel indices beyond the implemented range match no channel.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < CHANNELS; c++) begin
        dly_q[c]   <= DEFAULT_DLY_C;
        pulse_q[c] <= 1'b0;
      end
    end else if (cfg_we_i) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (cfg_ch_i == 4'(c)) begin
          dly_q[c]   <= cfg_dly_clamped;
          pulse_q[c] <= cfg_pulse_i;
        end
      end
    end
  end

  // Per-channel next-state logic; outputs are derived from the next state so
  // that the registered outputs line up with the state they describe
  always_comb begin
    rdy_d  = '0;
    id_d   = '0;
    busy_d = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      idl_d[c]   = idl_q[c];
      if (ce_i) begin
        if (!req_i[c]) begin
          state_d[c] = ST_IDLE;
        end else begin
          case (state_q[c])
            ST_IDLE: begin
              idl_d[c] = id_i[c*IDW +: IDW];
              if (dly_q[c] == '0) begin
                state_d[c] = ST_READY;
              end else begin
                state_d[c] = ST_COUNT;
                cnt_d[c]   = dly_q[c] - CW'(1);
              end
            end
            ST_COUNT: begin
              if (cnt_q[c] == '0) begin
                state_d[c] = ST_READY;
              end else begin
                cnt_d[c] = cnt_q[c] - CW'(1);
              end
            end
            ST_READY: begin
              if (pulse_q[c]) begin
                state_d[c] = ST_DONE;
              end
            end
            ST_DONE: begin
              state_d[c] = ST_DONE;
            end
            default: begin
              state_d[c] = ST_IDLE;
            end
          endcase
        end
      end
      if (state_d[c] == ST_READY) begin
        rdy_d[c]            = 1'b1;
        id_d[c*IDW +: IDW]  = idl_d[c];
      end
      if (state_d[c] == ST_COUNT) begin
        busy_d = 1'b1;
      end
    end
  end

  // Channel state and registered outputs; reset wins over the clock enable
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= ST_IDLE;
        cnt_q[c]   <= '0;
        idl_q[c]   <= '0;
      end
      rdy_o  <= '0;
      id_o   <= '0;
      busy_o <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        idl_q[c]   <= idl_d[c];
      end
      rdy_o  <= rdy_d;
      id_o   <= id_d;
      busy_o <= busy_d;
    end
  end

endmodule
